// File: rtl/issue_scoreboard.sv
// issue_scoreboard: N-wide in-order issue scoreboard with a DEPTH-entry commit-ID table.
// Define ISSUE_SCOREBOARD_BYPASS_EN to let same-cycle commits unblock hazards and free entries.

module issue_hz_chk #(
   parameter int DEPTH  = 8,
   parameter int REG_AW = 5
) (
   input  logic [DEPTH-1:0]             ent_busy,
   input  logic [DEPTH-1:0][REG_AW-1:0] ent_rd,
   input  logic                         rd_we,
   input  logic [REG_AW-1:0]            rd,
   input  logic [REG_AW-1:0]            rs1,
   input  logic [REG_AW-1:0]            rs2,
   output logic                         hazard
);
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_busy[i] && ent_rd[i] != '0) begin
            if ((rs1 != '0 && rs1 == ent_rd[i]) ||
                (rs2 != '0 && rs2 == ent_rd[i]) ||
                (rd_we && rd != '0 && rd == ent_rd[i]))
               hazard = 1'b1;
         end
      end
   end
endmodule

module issue_scoreboard #(
   parameter int ISSUE_W   = 2,
   parameter int DEPTH     = 8,
   parameter int ID_W      = $clog2(DEPTH),
   parameter int REG_AW    = 5,
   parameter int CMT_PORTS = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ISSUE_W-1:0]          inst_valid_i,
   input  logic [ISSUE_W-1:0]          inst_rd_we_i,
   input  logic [ISSUE_W*REG_AW-1:0]   inst_rd_i,
   input  logic [ISSUE_W*REG_AW-1:0]   inst_rs1_i,
   input  logic [ISSUE_W*REG_AW-1:0]   inst_rs2_i,
   input  logic [ISSUE_W-1:0]          inst_serial_i,
   input  logic                        flush_i,
   input  logic [CMT_PORTS-1:0]        commit_valid_i,
   input  logic [CMT_PORTS*ID_W-1:0]   commit_id_i,
   output logic [ISSUE_W-1:0]          issue_o,
   output logic [ISSUE_W*ID_W-1:0]     issue_id_o,
   output logic [$clog2(DEPTH):0]      inflight_cnt_o,
   output logic                        full_o,
   output logic                        empty_o
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic              vld;
      logic              rd_we;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              serial;
   } slot_req_t;

   slot_req_t [ISSUE_W-1:0]         req;
   logic [DEPTH-1:0]                tbl_vld;
   logic [DEPTH-1:0]                tbl_we;
   logic [DEPTH-1:0][REG_AW-1:0]    tbl_rd;
   logic [DEPTH-1:0]                cmt_hit;
   logic [DEPTH-1:0]                eff_vld;
   logic [DEPTH-1:0]                ent_busy;
   logic [DEPTH-1:0]                alloc_hit;
   logic [DEPTH-1:0]                taken;
   logic [ISSUE_W-1:0]              hz_tbl;
   logic [ISSUE_W-1:0]              intra_hz;
   logic [ISSUE_W-1:0]              serial_ok;
   logic [ISSUE_W-1:0]              alloc_ok;
   logic [ISSUE_W-1:0]              elig;
   logic [ISSUE_W:0]                chain;
   logic [ISSUE_W-1:0][ID_W-1:0]    alloc_id;
   logic [CNT_W-1:0]                cnt_nxt;

   // Per-slot unpacking and hazard check against the in-flight table
   for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
      assign req[k] = '{vld:    inst_valid_i[k],
                        rd_we:  inst_rd_we_i[k],
                        rd:     inst_rd_i[k*REG_AW +: REG_AW],
                        rs1:    inst_rs1_i[k*REG_AW +: REG_AW],
                        rs2:    inst_rs2_i[k*REG_AW +: REG_AW],
                        serial: inst_serial_i[k]};

      issue_hz_chk #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_hz (
         .ent_busy (ent_busy),
         .ent_rd   (tbl_rd),
         .rd_we    (req[k].rd_we),
         .rd       (req[k].rd),
         .rs1      (req[k].rs1),
         .rs2      (req[k].rs2),
         .hazard   (hz_tbl[k])
      );

      assign issue_id_o[k*ID_W +: ID_W] = alloc_id[k];
   end

   // A commit frees an entry only if it is valid; duplicate IDs collapse into one bit
   always_comb begin
      cmt_hit = '0;
      for (int p = 0; p < CMT_PORTS; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!rst && commit_valid_i[p] && tbl_vld[i] &&
                commit_id_i[p*ID_W +: ID_W] == ID_W'(i))
               cmt_hit[i] = 1'b1;
         end
      end
   end

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
   assign eff_vld = tbl_vld & ~cmt_hit;
`else
   assign eff_vld = tbl_vld;
`endif
   assign ent_busy = eff_vld & tbl_we;

   // Slot k takes the k-th lowest free index
   always_comb begin
      taken    = '0;
      alloc_ok = '0;
      alloc_id = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!alloc_ok[k] && !eff_vld[i] && !taken[i]) begin
               alloc_ok[k] = 1'b1;
               alloc_id[k] = ID_W'(i);
               taken[i]    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      intra_hz  = '0;
      serial_ok = '0;
      elig      = '0;
      chain     = '0;
      chain[0]  = !rst && !flush_i && !full_o;
      for (int k = 0; k < ISSUE_W; k++) begin
         serial_ok[k] = !req[k].serial || (k == 0 && empty_o);
         for (int j = 0; j < k; j++) begin
            if (req[j].serial)
               serial_ok[k] = 1'b0;
            if (req[j].vld && req[j].rd_we && req[j].rd != '0 &&
                (req[j].rd == req[k].rs1 || req[j].rd == req[k].rs2 ||
                 (req[k].rd_we && req[j].rd == req[k].rd)))
               intra_hz[k] = 1'b1;
         end
         elig[k]    = req[k].vld && !hz_tbl[k] && !intra_hz[k] && alloc_ok[k] && serial_ok[k];
         chain[k+1] = chain[k] && elig[k];
      end
   end
   assign issue_o = chain[ISSUE_W:1];

   always_comb begin
      alloc_hit = '0;
      cnt_nxt   = inflight_cnt_o;
      for (int k = 0; k < ISSUE_W; k++) begin
         if (issue_o[k]) begin
            alloc_hit[alloc_id[k]] = 1'b1;
            cnt_nxt = cnt_nxt + CNT_W'(1);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (cmt_hit[i])
            cnt_nxt = cnt_nxt - CNT_W'(1);
      end
   end

   // Allocation wins over a same-cycle commit of the same index
   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_vld        <= '0;
         tbl_we         <= '0;
         tbl_rd         <= '0;
         inflight_cnt_o <= '0;
         full_o         <= 1'b0;
         empty_o        <= 1'b1;
      end else begin
         tbl_vld <= (tbl_vld & ~cmt_hit) | alloc_hit;
         for (int k = 0; k < ISSUE_W; k++) begin
            if (issue_o[k]) begin
               tbl_rd[alloc_id[k]] <= req[k].rd;
               tbl_we[alloc_id[k]] <= req[k].rd_we && req[k].rd != '0;
            end
         end
         inflight_cnt_o <= cnt_nxt;
         full_o         <= (cnt_nxt == CNT_W'(DEPTH));
         empty_o        <= (cnt_nxt == '0);
      end
   end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard (ISSUE_W=2, DEPTH=4, CMT_PORTS=2).
module tb_issue_scoreboard;
   localparam int IW = 2, DEP = 4, IDW = 2, RAW = 5, CP = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [IW-1:0]     inst_valid, inst_rd_we, inst_serial;
   logic [IW*RAW-1:0] inst_rd, inst_rs1, inst_rs2;
   logic              flush;
   logic [CP-1:0]     commit_valid;
   logic [CP*IDW-1:0] commit_id;
   logic [IW-1:0]     issue;
   logic [IW*IDW-1:0] issue_id;
   logic [2:0]        cnt;
   logic              full, empty;

   int n_cmp = 0;
   int n_err = 0;

   issue_scoreboard #(.ISSUE_W(IW), .DEPTH(DEP), .ID_W(IDW), .REG_AW(RAW), .CMT_PORTS(CP)) dut (
      .clk            (clk),
      .rst            (rst),
      .inst_valid_i   (inst_valid),
      .inst_rd_we_i   (inst_rd_we),
      .inst_rd_i      (inst_rd),
      .inst_rs1_i     (inst_rs1),
      .inst_rs2_i     (inst_rs2),
      .inst_serial_i  (inst_serial),
      .flush_i        (flush),
      .commit_valid_i (commit_valid),
      .commit_id_i    (commit_id),
      .issue_o        (issue),
      .issue_id_o     (issue_id),
      .inflight_cnt_o (cnt),
      .full_o         (full),
      .empty_o        (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      inst_valid = '0; inst_rd_we = '0; inst_serial = '0;
      inst_rd = '0; inst_rs1 = '0; inst_rs2 = '0;
      commit_valid = '0; commit_id = '0;
   endtask

   task automatic slot(input int k, input logic v, input logic we, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic ser);
      inst_valid[k] = v;  inst_rd_we[k] = we; inst_serial[k] = ser;
      inst_rd[k*RAW +: RAW] = rd; inst_rs1[k*RAW +: RAW] = rs1; inst_rs2[k*RAW +: RAW] = rs2;
   endtask

   task automatic cmt(input int p, input logic [1:0] id);
      commit_valid[p] = 1'b1;
      commit_id[p*IDW +: IDW] = id;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      idle(); flush = 1'b0; rst = 1'b1;
      tick(); tick();
      // reset state, group presented while in reset
      slot(0, 1, 1, 1, 2, 3, 0); slot(1, 1, 1, 4, 5, 6, 0);
      @(negedge clk);
      chk("rst_issue", issue, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      rst = 1'b0; #1;
      chk("grp_issue", issue, 2'b11);
      chk("grp_id0", issue_id[1:0], 0);
      chk("grp_id1", issue_id[3:2], 1);
      tick();
      chk("grp_cnt", cnt, 2);
      chk("grp_empty", empty, 0);

      // intra-group RAW on x5
      idle(); slot(0, 1, 1, 5, 0, 0, 0); slot(1, 1, 1, 8, 5, 0, 0);
      @(negedge clk);
      chk("intra_issue", issue, 2'b01);
      chk("intra_id0", issue_id[1:0], 2);
      tick();
      chk("intra_cnt", cnt, 3);

      // dependent re-presented while the x5 writer (ID 2) commits
      idle(); slot(0, 1, 1, 8, 5, 0, 0); cmt(0, 2);
      @(negedge clk);
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
      chk("raw_cmt_issue", issue, 2'b01);
      chk("raw_cmt_id", issue_id[1:0], 2);
      tick();
      chk("raw_cmt_cnt", cnt, 3);
`else
      chk("raw_cmt_issue", issue, 2'b00);
      tick();
      chk("raw_cmt_cnt", cnt, 2);
`endif
      idle(); slot(0, 1, 1, 8, 5, 0, 0);
      @(negedge clk);
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
      chk("raw_next_issue", issue, 2'b00);
`else
      chk("raw_next_issue", issue, 2'b01);
      chk("raw_next_id", issue_id[1:0], 2);
`endif
      tick();
      chk("raw_next_cnt", cnt, 3);

      // x0 writer fills the last entry
      idle(); slot(0, 1, 1, 0, 9, 0, 0);
      @(negedge clk);
      chk("x0w_issue", issue, 2'b01);
      chk("x0w_id", issue_id[1:0], 3);
      tick();
      chk("fill_cnt", cnt, 4);
      chk("fill_full", full, 1);

      // full: nothing issues; same ID on both ports frees once
      idle(); slot(0, 1, 1, 10, 11, 0, 0); cmt(0, 2); cmt(1, 2);
      @(negedge clk);
      chk("full_issue", issue, 2'b00);
      tick();
      chk("dup_cmt_cnt", cnt, 3);
      chk("dup_cmt_full", full, 0);

      // rs1=x0 with x0 writer in flight issues into ID 2; slot1 WAW on x4
      idle(); slot(0, 1, 1, 10, 0, 12, 0); slot(1, 1, 1, 4, 13, 14, 0);
      @(negedge clk);
      chk("x0rs_issue", issue, 2'b01);
      chk("x0rs_id", issue_id[1:0], 2);
      tick();
      chk("x0rs_cnt", cnt, 4);

      idle(); cmt(0, 0); cmt(1, 3);
      tick();
      chk("two_cmt_cnt", cnt, 2);

      // in flight: x4 (ID1), x10 (ID2)
      idle(); slot(0, 1, 1, 4, 15, 16, 0); slot(1, 1, 1, 17, 18, 19, 0);
      @(negedge clk);
      chk("waw_issue", issue, 2'b00);
      slot(0, 1, 1, 20, 0, 10, 0); #1;
      chk("raw_rs2_issue", issue, 2'b00);
      slot(0, 1, 0, 4, 15, 16, 0); #1;
      chk("nowe_issue", issue, 2'b11);
      chk("nowe_id0", issue_id[1:0], 0);
      chk("nowe_id1", issue_id[3:2], 3);
      idle();
      tick();
      chk("hold_cnt", cnt, 2);

      idle(); cmt(0, 1);
      tick();
      chk("one_left_cnt", cnt, 1);

      // serial with one in flight, then alone on empty table
      idle(); slot(0, 1, 0, 0, 0, 0, 1); slot(1, 1, 1, 20, 21, 22, 0); cmt(0, 2);
      @(negedge clk);
      chk("ser_busy_issue", issue, 2'b00);
      tick();
      chk("ser_empty", empty, 1);
      chk("ser_cnt0", cnt, 0);
      idle(); slot(0, 1, 0, 0, 0, 0, 1); slot(1, 1, 1, 20, 21, 22, 0);
      @(negedge clk);
      chk("ser_alone_issue", issue, 2'b01);
      chk("ser_alone_id", issue_id[1:0], 0);
      tick();
      chk("ser_cnt1", cnt, 1);

      // flush squashes the group, table unchanged
      idle(); slot(0, 1, 1, 3, 0, 0, 0); slot(1, 1, 1, 6, 0, 0, 0); flush = 1'b1;
      @(negedge clk);
      chk("flush_issue", issue, 2'b00);
      tick();
      chk("flush_cnt", cnt, 1);
      flush = 1'b0;
      @(negedge clk);
      chk("post_flush_issue", issue, 2'b11);
      chk("post_flush_id0", issue_id[1:0], 1);
      chk("post_flush_id1", issue_id[3:2], 2);
      tick();
      chk("post_flush_cnt", cnt, 3);

      // mid-operation reset with a commit pending
      idle(); slot(0, 1, 1, 3, 0, 0, 0); slot(1, 1, 1, 6, 0, 0, 0); cmt(0, 0); rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_issue", issue, 2'b00);
      tick();
      chk("rst_mid_cnt", cnt, 0);
      chk("rst_mid_empty", empty, 1);
      chk("rst_mid_full", full, 0);
      idle(); rst = 1'b0; slot(0, 1, 1, 3, 0, 0, 0); slot(1, 1, 1, 6, 0, 0, 0);
      @(negedge clk);
      chk("after_rst_issue", issue, 2'b11);
      chk("after_rst_id0", issue_id[1:0], 0);
      chk("after_rst_id1", issue_id[3:2], 1);
      tick();
      chk("after_rst_cnt", cnt, 2);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
